// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial arithmetic blocks (serial_adder,
// serial_subtractor): the common control state encoding and a helper that
// sizes the bit counter.
// -----------------------------------------------------------------------------
package serial_arith_pkg;

  // Control states shared by all serial arithmetic blocks.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to index every position of a WIDTH-bit operand.
  // Never returns less than 1 so the counter always exists.
  function automatic int count_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : serial_arith_pkg

// File: rtl/full_subtractor_bit.sv
// -----------------------------------------------------------------------------
// full_subtractor_bit
// One-bit full subtractor: computes a - b - bin.
// Ports:
//   a, b  : operand bits
//   bin   : borrow in from the previous (less significant) bit
//   d     : difference bit
//   bout  : borrow out to the next bit
// -----------------------------------------------------------------------------
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor_bit

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial two's-complement subtractor. Computes a - b one bit per enabled
// cycle, LSB first, with a start/ready handshake and a signed-overflow flag.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : load a_in/b_in; accepted only while ready=1
//   enable      : process one bit this cycle while shifting; low stalls
//   a_in, b_in  : minuend and subtrahend
//   ready       : block can accept start (idle or holding a result)
//   diff_out    : a - b mod 2^WIDTH, valid while done=1
//   borrow_out  : final borrow (a < b unsigned)
//   overflow    : signed overflow of the subtraction
//   done        : result valid, held until the next accepted start
// All outputs are registered.
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             enable,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             overflow,
  output logic             done
);

  localparam int CW = count_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] diff_sr;
  logic             bw;
  logic [CW-1:0]    count;
  logic             a_msb;
  logic             b_msb;

  logic             d;
  logic             bw_next;
  logic [WIDTH-1:0] diff_full;
  logic             last_bit;

  full_subtractor_bit u_bit (
    .a    (a_shift[0]),
    .b    (b_shift[0]),
    .bin  (bw),
    .d    (d),
    .bout (bw_next)
  );

  // Difference register with the bit being computed this cycle merged in, so
  // the final cycle can publish the complete result in one step.
  // NOTE: the copy of diff_sr comes first so every bit has a value on every
  // path; without that default the partial write would infer a latch.
  always_comb begin
    diff_full        = diff_sr;
    diff_full[count] = d;
  end

  assign last_bit = (count == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: every register, including the operand shift registers, is reset;
  // the block is small and a fully known state after reset is worth it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_shift    <= '0;
      b_shift    <= '0;
      diff_sr    <= '0;
      bw         <= 1'b0;
      count      <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ready      <= 1'b1;
      diff_out   <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // enable has no meaning here; only an accepted start moves on.
          if (start) begin
            a_shift    <= a_in;
            b_shift    <= b_in;
            a_msb      <= a_in[WIDTH-1];
            b_msb      <= b_in[WIDTH-1];
            diff_sr    <= '0;
            bw         <= 1'b0;
            count      <= '0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            ready      <= 1'b0;
            state      <= SHIFT;
          end
        end

        SHIFT: begin
          // start is ignored while shifting; enable=0 holds everything.
          if (enable) begin
            diff_sr <= diff_full;
            a_shift <= {1'b0, a_shift[WIDTH-1:1]};
            b_shift <= {1'b0, b_shift[WIDTH-1:1]};
            bw      <= bw_next;
            count   <= count + CW'(1);
            if (last_bit) begin
              diff_out   <= diff_full;
              borrow_out <= bw_next;
              // Signed overflow: operand signs differ and the result sign
              // does not follow the minuend.
              overflow   <= (a_msb ^ b_msb) & (diff_full[WIDTH-1] ^ a_msb);
              done       <= 1'b1;
              ready      <= 1'b1;
              state      <= DONE;
            end
          end
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH=8). A behavioural model
// tracks the handshake and computes results with plain arithmetic; a compare
// process checks every output on every falling edge, and the directed
// sequence pins hand-computed results and latencies.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             enable;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             ready;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;
  logic             overflow;
  logic             done;

  int n_checks = 0;
  int n_pass   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .enable     (enable),
    .a_in       (a_in),
    .b_in       (b_in),
    .ready      (ready),
    .diff_out   (diff_out),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: busy flag plus a count of enabled cycles; the result is
  // ordinary subtraction once WIDTH enabled cycles have elapsed.
  // ---------------------------------------------------------------------------
  logic             m_busy;
  int               m_cnt;
  logic [WIDTH-1:0] m_a, m_b;
  logic [WIDTH-1:0] exp_diff;
  logic             exp_bor, exp_ovf, exp_done, exp_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_cnt = 0; m_a = '0; m_b = '0;
      exp_diff = '0; exp_bor = 1'b0; exp_ovf = 1'b0; exp_done = 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_a = a_in; m_b = b_in; m_busy = 1'b1; m_cnt = 0;
        exp_diff = '0; exp_bor = 1'b0; exp_ovf = 1'b0; exp_done = 1'b0;
      end
    end else if (enable) begin
      m_cnt++;
      if (m_cnt == WIDTH) begin
        exp_diff = m_a - m_b;
        exp_bor  = (m_a < m_b);
        exp_ovf  = (m_a[WIDTH-1] != m_b[WIDTH-1]) && (exp_diff[WIDTH-1] != m_a[WIDTH-1]);
        exp_done = 1'b1;
        m_busy   = 1'b0;
      end
    end
    exp_ready = !m_busy;
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    check("cyc_ready",  {31'd0, ready},      {31'd0, exp_ready});
    check("cyc_done",   {31'd0, done},       {31'd0, exp_done});
    check("cyc_diff",   {24'd0, diff_out},   {24'd0, exp_diff});
    check("cyc_borrow", {31'd0, borrow_out}, {31'd0, exp_bor});
    check("cyc_ovf",    {31'd0, overflow},   {31'd0, exp_ovf});
  end

  // Run one operation. Called #1 after an edge; returns #1 after the edge on
  // which done rose. lat counts edges after the accept edge. Optionally stalls
  // stall_n cycles once stall_at bits are processed, and optionally pulses a
  // foreign start during SHIFT.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int stall_at, input int stall_n, input bit inject,
                       output int lat);
    int bits;
    int stalled;
    start = 1'b1; a_in = a; b_in = b; enable = 1'b1;
    @(posedge clk); #1;
    check("accept_ready", {31'd0, ready}, 32'd0);
    check("accept_done",  {31'd0, done},  32'd0);
    start = 1'b0;
    lat = 0; bits = 0; stalled = 0;
    while (!done && lat < 64) begin
      if (bits == stall_at && stalled < stall_n) begin
        enable = 1'b0; stalled++;
      end else begin
        enable = 1'b1;
      end
      if (inject && lat == 2) begin
        start = 1'b1; a_in = 8'h00; b_in = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (enable) bits++;
    end
    start = 1'b0;
    check("op_done", {31'd0, done}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] d,
                              input logic bor, input logic ovf);
    check({tag, "_diff"},   {24'd0, diff_out},   {24'd0, d});
    check({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, bor});
    check({tag, "_ovf"},    {31'd0, overflow},   {31'd0, ovf});
  endtask

  int lat;

  initial begin
    rst_n = 1'b0; start = 1'b0; enable = 1'b0; a_in = '0; b_in = '0;
    #12;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_diff",  {24'd0, diff_out}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic: 5 - 3
    do_op(8'h05, 8'h03, -1, 0, 1'b0, lat);
    check("lat_basic", lat, 32'd8);
    check_result("t1", 8'h02, 1'b0, 1'b0);

    // 3 - 5 borrows
    do_op(8'h03, 8'h05, -1, 0, 1'b0, lat);
    check_result("t2", 8'hFE, 1'b1, 1'b0);

    // Signed overflow both directions
    do_op(8'h80, 8'h01, -1, 0, 1'b0, lat);
    check_result("t3", 8'h7F, 1'b0, 1'b1);
    do_op(8'h7F, 8'hFF, -1, 0, 1'b0, lat);
    check_result("t4", 8'h80, 1'b1, 1'b1);

    // Stall 3 cycles after bit 2
    do_op(8'hA5, 8'h5A, 3, 3, 1'b0, lat);
    check("lat_stall", lat, 32'd11);
    check_result("t5", 8'h4B, 1'b0, 1'b1);

    // Foreign start during SHIFT is ignored
    do_op(8'hC3, 8'h3C, -1, 0, 1'b1, lat);
    check("lat_inject", lat, 32'd8);
    check_result("t6", 8'h87, 1'b0, 1'b0);

    // Asynchronous reset after bit 4
    start = 1'b1; a_in = 8'h55; b_in = 8'h22; enable = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready",  {31'd0, ready},      32'd1);
    check("arst_done",   {31'd0, done},       32'd0);
    check("arst_diff",   {24'd0, diff_out},   32'd0);
    check("arst_borrow", {31'd0, borrow_out}, 32'd0);
    check("arst_ovf",    {31'd0, overflow},   32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'h22, 8'h11, -1, 0, 1'b0, lat);
    check("lat_after_rst", lat, 32'd8);
    check_result("t7", 8'h11, 1'b0, 1'b0);

    // Back-to-back with no idle cycle between operations
    do_op(8'h10, 8'h01, -1, 0, 1'b0, lat);
    check_result("t8", 8'h0F, 1'b0, 1'b0);
    do_op(8'h00, 8'h00, -1, 0, 1'b0, lat);
    check("lat_b2b", lat, 32'd8);
    check_result("t9", 8'h00, 1'b0, 1'b0);

    // enable is ignored in DONE: outputs hold
    enable = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("hold_done", {31'd0, done}, 32'd1);
    check_result("t10", 8'h00, 1'b0, 1'b0);

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_subtractor
